// File: rtl/wbu_sched.sv
// Writeback channel scheduler: grants up to two regfile write channels per cycle using
// starvation override, optional fixed priority (WBU_SCHED_PRIO_EN), then round-robin.
module wbu_sched #(
  parameter int unsigned         NUM_REQ      = 8,
  parameter int unsigned         STARVE_LIMIT = 4,
  parameter logic [NUM_REQ-1:0]  PRIO_MASK    = NUM_REQ'(8'h80)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  input  logic               ch2_en_i,
  input  logic               wb_stall_i,
  output logic               ch1_valid_o,
  output logic               ch2_valid_o,
  output logic [2:0]         ch1_sel_o,
  output logic [2:0]         ch2_sel_o,
  output logic               starve_evt_o
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;
`ifdef WBU_SCHED_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q [NUM_REQ];
  logic             starve_evt_q;

  logic [NUM_REQ-1:0] forced, prio, avail1, avail2;
  logic               rr1, rr2, frc1, frc2;

  // Pick one requester from avail: forced first, then priority, then round-robin from ptr.
  function automatic void pick(
    input  logic [NUM_REQ-1:0] avail,
    input  logic [NUM_REQ-1:0] frc_m,
    input  logic [NUM_REQ-1:0] prio_m,
    input  logic [SEL_W-1:0]   ptr,
    output logic               vld,
    output logic [SEL_W-1:0]   sel,
    output logic               is_rr,
    output logic               is_frc
  );
    logic [NUM_REQ-1:0] cand;
    int unsigned        idx;
    vld    = 1'b0;
    sel    = '0;
    is_rr  = 1'b0;
    is_frc = 1'b0;
    if (|(avail & frc_m)) begin
      cand   = avail & frc_m;
      is_frc = 1'b1;
    end else if (|(avail & prio_m)) begin
      cand = avail & prio_m;
    end else begin
      cand  = '0;
      is_rr = |avail;
    end
    if (is_rr) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (avail[idx] && !vld) begin
          vld = 1'b1;
          sel = SEL_W'(idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cand[i] && !vld) begin
          vld = 1'b1;
          sel = SEL_W'(i);
        end
      end
    end
  endfunction

  always_comb begin
    forced      = '0;
    prio        = req_valid_i & (PRIO_MASK & {NUM_REQ{PRIO_EN}});
    avail1      = (rst_n && !wb_stall_i) ? req_valid_i : '0;
    avail2      = '0;
    req_ready_o = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      forced[i] = req_valid_i[i] && (wait_cnt_q[i] == CNT_W'(STARVE_LIMIT));

    pick(avail1, forced, prio, rr_ptr_q, ch1_valid_o, ch1_sel_o, rr1, frc1);

    // Channel 2 draws from the same order with the channel-1 winner removed.
    if (ch2_en_i) begin
      avail2 = avail1;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (ch1_valid_o && ch1_sel_o == SEL_W'(i)) avail2[i] = 1'b0;
    end
    pick(avail2, forced, prio, rr_ptr_q, ch2_valid_o, ch2_sel_o, rr2, frc2);

    for (int unsigned i = 0; i < NUM_REQ; i++)
      req_ready_o[i] = (ch1_valid_o && ch1_sel_o == SEL_W'(i)) ||
                       (ch2_valid_o && ch2_sel_o == SEL_W'(i));

    if (rr2)      rr_ptr_d = SEL_W'((int'(ch2_sel_o) + 1) % NUM_REQ);
    else if (rr1) rr_ptr_d = SEL_W'((int'(ch1_sel_o) + 1) % NUM_REQ);
  end

  // Pointer, starvation counters and forced-grant pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      starve_evt_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_evt_q <= frc1 | frc2;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid_i[i] && !req_ready_o[i]) begin
          if (wait_cnt_q[i] < CNT_W'(STARVE_LIMIT)) wait_cnt_q[i] <= wait_cnt_q[i] + CNT_W'(1);
        end else begin
          wait_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign starve_evt_o = starve_evt_q;

endmodule

// File: tb/tb_wbu_sched.sv
// Directed bench for wbu_sched: round-robin rotation, channel-2 gating, stall,
// starvation override and mid-run reset; priority ranking when WBU_SCHED_PRIO_EN is set.
module tb_wbu_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_valid, req_ready;
  logic       ch2_en, stall;
  logic       ch1_valid, ch2_valid, starve_evt;
  logic [2:0] ch1_sel, ch2_sel;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // PRIO_MASK cleared so this instance behaves the same with or without the macro.
  wbu_sched #(.NUM_REQ(8), .STARVE_LIMIT(4), .PRIO_MASK(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ch2_en_i(ch2_en), .wb_stall_i(stall), .ch1_valid_o(ch1_valid), .ch2_valid_o(ch2_valid),
    .ch1_sel_o(ch1_sel), .ch2_sel_o(ch2_sel), .starve_evt_o(starve_evt)
  );

`ifdef WBU_SCHED_PRIO_EN
  logic [7:0] p_valid = '0, p_ready;
  logic       p_ch1_valid, p_ch2_valid, p_starve;
  logic [2:0] p_ch1_sel, p_ch2_sel;
  wbu_sched #(.NUM_REQ(8), .STARVE_LIMIT(3), .PRIO_MASK(8'hC0)) u_prio (
    .clk(clk), .rst_n(rst_n), .req_valid_i(p_valid), .req_ready_o(p_ready),
    .ch2_en_i(1'b1), .wb_stall_i(1'b0), .ch1_valid_o(p_ch1_valid), .ch2_valid_o(p_ch2_valid),
    .ch1_sel_o(p_ch1_sel), .ch2_sel_o(p_ch2_sel), .starve_evt_o(p_starve)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] rdy, input logic v1,
                         input logic [2:0] s1, input logic v2, input logic [2:0] s2);
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".ch1_valid"}, 32'(ch1_valid), 32'(v1));
    chk({tag, ".ch1_sel"}, 32'(ch1_sel), 32'(s1));
    chk({tag, ".ch2_valid"}, 32'(ch2_valid), 32'(v2));
    chk({tag, ".ch2_sel"}, 32'(ch2_sel), 32'(s2));
  endtask

  // Apply inputs just after a rising edge, then move to the sampling (falling) edge.
  task automatic drive(input logic [7:0] v, input logic c2, input logic st);
    req_valid = v;
    ch2_en    = c2;
    stall     = st;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    adv();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; ch2_en = 1'b0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 8'h00, 0, 0, 0, 0);
    chk("reset.starve", 32'(starve_evt), 0);
    adv();
    rst_n = 1'b1;

    // All eight valid with both channels: pairs rotate and the pointer wraps.
    drive(8'hFF, 1, 0); chk_out("rr_c0", 8'h03, 1, 0, 1, 1); adv();
    drive(8'hFF, 1, 0); chk_out("rr_c1", 8'h0C, 1, 2, 1, 3); adv();
    drive(8'hFF, 1, 0); chk_out("rr_c2", 8'h30, 1, 4, 1, 5); adv();
    drive(8'hFF, 1, 0); chk_out("rr_c3", 8'hC0, 1, 6, 1, 7); adv();
    drive(8'hFF, 1, 0); chk_out("rr_wrap", 8'h03, 1, 0, 1, 1); adv();

    // Reset asserted mid-run with requests still held.
    reset_pulse();
    drive(8'hFF, 1, 0); chk_out("rs_c0", 8'h03, 1, 0, 1, 1); adv();
    drive(8'hFF, 1, 0); chk_out("rs_c1", 8'h0C, 1, 2, 1, 3); adv();
    rst_n = 1'b0;
    drive(8'hFF, 1, 0); chk_out("rs_mid", 8'h00, 0, 0, 0, 0);
    chk("rs_mid.starve", 32'(starve_evt), 0);
    adv();
    rst_n = 1'b1;
    drive(8'hFF, 1, 0); chk_out("rs_restart", 8'h03, 1, 0, 1, 1); adv();

    // Single requester 5 from ptr 0, then ptr must be 6.
    reset_pulse();
    drive(8'h20, 1, 0); chk_out("single5", 8'h20, 1, 5, 0, 0); adv();
    drive(8'hFF, 1, 0); chk_out("after5", 8'hC0, 1, 6, 1, 7); adv();

    // Channel 2 disabled: one grant per cycle.
    drive(8'h03, 0, 0); chk_out("ch2off_a", 8'h01, 1, 0, 0, 0); adv();
    drive(8'h03, 0, 0); chk_out("ch2off_b", 8'h02, 1, 1, 0, 0); adv();

    // Stall blocks everything; the request goes through once released.
    for (int k = 0; k < 3; k++) begin
      drive(8'h04, 1, 1); chk_out("stall", 8'h00, 0, 0, 0, 0); adv();
    end
    drive(8'h04, 1, 0); chk_out("unstall", 8'h04, 1, 2, 0, 0); adv();

    // Five requesters on one channel: requester 4 reaches the limit in cycle 4.
    reset_pulse();
    drive(8'h1F, 0, 0); chk_out("sv_c0", 8'h01, 1, 0, 0, 0); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c1", 8'h02, 1, 1, 0, 0); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c2", 8'h04, 1, 2, 0, 0); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c3", 8'h08, 1, 3, 0, 0); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c4", 8'h10, 1, 4, 0, 0);
    chk("sv_c4.starve", 32'(starve_evt), 0); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c5", 8'h01, 1, 0, 0, 0);
    chk("sv_c5.starve", 32'(starve_evt), 1); adv();
    drive(8'h1F, 0, 0); chk_out("sv_c6", 8'h02, 1, 1, 0, 0);
    chk("sv_c6.starve", 32'(starve_evt), 1); adv();
    drive(8'h00, 0, 0); chk_out("sv_idle", 8'h00, 0, 0, 0, 0);
    chk("sv_idle.starve", 32'(starve_evt), 1); adv();
    drive(8'h00, 0, 0); chk("sv_end.starve", 32'(starve_evt), 0); adv();

`ifdef WBU_SCHED_PRIO_EN
    // Priority requesters 6,7 win until requester 0 is forced.
    reset_pulse();
    p_valid = 8'hC1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prio.ready", 32'(p_ready), 32'h0C0);
      chk("prio.sel1", 32'(p_ch1_sel), 6);
      chk("prio.sel2", 32'(p_ch2_sel), 7);
      adv();
    end
    @(negedge clk);
    chk("prio_force.ready", 32'(p_ready), 32'h041);
    chk("prio_force.sel1", 32'(p_ch1_sel), 0);
    chk("prio_force.sel2", 32'(p_ch2_sel), 6);
    chk("prio_force.valid2", 32'(p_ch2_valid & p_ch1_valid), 1);
    adv();
    @(negedge clk);
    chk("prio_force.starve", 32'(p_starve), 1);
    adv();
    p_valid = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wbu_sched.md
WBU_SCHED -- requirements
Module: wbu_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, number of writeback requesters (index 7 = LSU, 6 = CSR, 0..5 = ALU1/ALU2/MUL1/MUL2/DIV1/DIV2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive unserved cycles after which a requester is forced; legal range 1..15.
REQ-003 The block SHALL have parameter PRIO_MASK, default 8'h80, marking the fixed-priority requesters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port req_valid_i, input, NUM_REQ bits: requester i holds a regfile write.
REQ-007 The block SHALL have port req_ready_o, output, NUM_REQ bits: requester i is granted this cycle.
REQ-008 The block SHALL have port ch2_en_i, input, 1 bit: write channel 2 is available.
REQ-009 The block SHALL have port wb_stall_i, input, 1 bit: the regfile cannot accept writes this cycle.
REQ-010 The block SHALL have ports ch1_valid_o and ch2_valid_o, output, 1 bit each: the channel carries a grant.
REQ-011 The block SHALL have ports ch1_sel_o and ch2_sel_o, output, 3 bits each: index of the granted requester.
REQ-012 The block SHALL have port starve_evt_o, output, 1 bit: registered pulse, one cycle after any forced grant.

Function
REQ-013 Grants SHALL be combinational from req_valid_i and registered state, with zero-cycle latency; a transfer occurs when req_valid_i[i] and req_ready_o[i] are both 1.
REQ-014 Requesters SHALL hold valid and data until ready; the block SHALL NOT require valid to drop after a grant.
REQ-015 Channel 1 SHALL be filled by the first available source in this order: forced requester (lowest index with wait_cnt == STARVE_LIMIT); then PRIO_MASK requester, lowest index first, if the macro is defined; then round-robin.
REQ-016 Channel 2 SHALL be filled by the next source in the same order, excluding the channel-1 requester.
REQ-017 Channel 2 SHALL only be filled when ch2_en_i=1.
REQ-018 Round-robin SHALL pick the first valid index scanning upward from rr_ptr_q, modulo NUM_REQ.
REQ-019 A requester SHALL never be granted on both channels.
REQ-020 When ch2_valid_o=1, ch1_valid_o SHALL also be 1.
REQ-021 When wb_stall_i=1, all grants, valids and req_ready_o SHALL be 0.
REQ-022 When a channel is not valid, its sel output SHALL be 0.
REQ-023 On each cycle with at least one round-robin grant, rr_ptr_q SHALL become (last RR-granted index + 1) mod NUM_REQ, where the last is channel 2 if RR-granted, otherwise channel 1.
REQ-024 On a cycle with no round-robin grant, rr_ptr_q SHALL hold; the pointer wraps 7 -> 0.
REQ-025 wait_cnt[i] (4 bits) SHALL increment, saturating at STARVE_LIMIT, when req_valid_i[i]=1 and req_ready_o[i]=0, including stalled cycles.
REQ-026 wait_cnt[i] SHALL clear when the requester is granted or req_valid_i[i]=0.
REQ-027 If two or more requesters are starved simultaneously, the lowest index SHALL take channel 1 and the next lowest SHALL take channel 2 (if ch2_en_i=1).
REQ-028 req_ready_o[i] SHALL equal (ch1_valid_o & ch1_sel_o==i) | (ch2_valid_o & ch2_sel_o==i).

Reset
REQ-029 While rst_n=0, rr_ptr_q, every wait_cnt and starve_evt_o SHALL be 0.
REQ-030 With all req_valid_i=0, all combinational outputs SHALL be 0 during reset.
REQ-031 Reset asserted mid-operation SHALL clear state immediately; the first post-reset grant SHALL scan from index 0.

Configuration
REQ-032 With WBU_SCHED_PRIO_EN defined, PRIO_MASK requesters SHALL rank above round-robin (REQ-015).
REQ-033 Without WBU_SCHED_PRIO_EN, PRIO_MASK SHALL be ignored and arbitration SHALL be starvation override plus round-robin only.

Verification
REQ-034 After reset, all 8 valid, ch2_en_i=1 -> cycle 0 grants 0,1 (ptr=2); cycle 1 grants 2,3; cycle 3 grants 6,7; ptr wraps to 0.
REQ-035 Only req 5 valid, ptr=0 -> ch1_sel_o=5, ch2_valid_o=0, ptr=6 next cycle.
REQ-036 ch2_en_i=0, reqs 0 and 1 valid -> only 0 granted, ptr=1; next cycle 1 granted.
REQ-037 wb_stall_i=1 for 3 cycles with req 2 valid -> no ready asserted, wait_cnt[2]=3; ready returns on the first unstalled cycle.
REQ-038 Macro defined, PRIO_MASK=8'hC0, STARVE_LIMIT=3, reqs 0,6,7 held valid -> cycles 0-2 grant 6,7; cycle 3 grants 0 (ch1) and 6 (ch2); starve_evt_o=1 in cycle 4.
REQ-039 Reset asserted in cycle 2 of REQ-034 -> all outputs 0; after release, grants restart at 0,1.
